// File: rtl/gb_pkg.sv
// gb_pkg: shared Game Boy I/O addresses and timer types
package gb_pkg;
  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;
  localparam logic [15:0] ADDR_IF   = 16'hFF0F;
  typedef enum logic [1:0] {
    TAC_4096 = 2'b00,
    TAC_262K = 2'b01,
    TAC_65K  = 2'b10,
    TAC_16K  = 2'b11
  } tac_sel_t;
  typedef enum logic [1:0] {T_RUN, T_WAIT, T_RELOAD} timer_state_t;
endpackage

// File: rtl/gb_div_counter.sv
// gb_div_counter: free-running 16-bit divider, TAC tap mux and falling-edge TIMA increment
// Ports: Clk/reset_n; div_clr_i (DIV write), tac_i (TAC value after this edge);
//        div_o (DIV byte), tima_inc_o (TIMA increments at this edge)
module gb_div_counter
  import gb_pkg::*;
(
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       div_clr_i,
  input  logic [2:0] tac_i,
  output logic [7:0] div_o,
  output logic       tima_inc_o
);
  logic [15:0] div_q, div_d;
  logic        tick_q, tick_d, tap;
  tac_sel_t    sel;
  // tick is judged on the post-edge values, so a DIV clear or TAC change that
  // drops it counts as a falling edge just like the divider rolling over
  always_comb begin
    div_d      = div_clr_i ? 16'd0 : div_q + 16'd1;
    sel        = tac_sel_t'(tac_i[1:0]);
    tap        = sel == TAC_262K ? div_d[3] : sel == TAC_65K ? div_d[5] : sel == TAC_16K ? div_d[7] : div_d[9];
    tick_d     = tac_i[2] & tap;
    tima_inc_o = tick_q & ~tick_d;
    div_o      = div_q[15:8];
  end
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
endmodule

// File: rtl/gb_timer.sv
// gb_timer: DMG timer/divider registers FF04-FF07 with delayed TIMA reload and timer irq
// Ports: Clk/reset_n; mem_addr/mem_wren/wr_data (CPU write side);
//        rd_data/rd_sel (read mux, FF when unselected); irq_timer (one-clock IF bit 2 request)
module gb_timer
  import gb_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = ADDR_DIV,
  parameter int          OVF_DELAY = 4
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] mem_addr,
  input  logic        mem_wren,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        rd_sel,
  output logic        irq_timer
);
  localparam int CW = OVF_DELAY > 1 ? $clog2(OVF_DELAY) : 1;
  timer_state_t  state_q;
  logic [7:0]    tima_q, tma_q, div;
  logic [2:0]    tac_q, tac_d;
  logic [CW-1:0] ovf_cnt_q;
  logic [15:0]   off;
  logic          we_div, we_tima, we_tma, we_tac, tima_inc, irq_q;
  always_comb begin
    off       = mem_addr - BASE_ADDR;
    rd_sel    = off < 16'd4;
    we_div    = mem_wren & rd_sel & (off[1:0] == 2'd0);
    we_tima   = mem_wren & rd_sel & (off[1:0] == 2'd1);
    we_tma    = mem_wren & rd_sel & (off[1:0] == 2'd2);
    we_tac    = mem_wren & rd_sel & (off[1:0] == 2'd3);
    tac_d     = we_tac ? wr_data[2:0] : tac_q;
    rd_data   = !rd_sel ? 8'hFF : off[1:0] == 2'd0 ? div : off[1:0] == 2'd1 ? tima_q : off[1:0] == 2'd2 ? tma_q : {5'b11111, tac_q};
    irq_timer = irq_q;
  end
  gb_div_counter u_div (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .div_clr_i (we_div),
    .tac_i     (tac_d),
    .div_o     (div),
    .tima_inc_o(tima_inc)
  );
  // WAIT is left on the edge where ovf_cnt reaches 0, so RELOAD is the last
  // cycle TIMA reads 00 and the reload plus irq land on the edge after it
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= T_RUN;
      tima_q    <= '0;
      tma_q     <= '0;
      tac_q     <= '0;
      ovf_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      tac_q <= tac_d;
      irq_q <= state_q == T_RELOAD;
      if (we_tma) tma_q <= wr_data;
      case (state_q)
        T_RUN:
          if (we_tima) tima_q <= wr_data;
          else if (tima_inc && tima_q == 8'hFF) begin
            tima_q    <= '0;
            ovf_cnt_q <= CW'(OVF_DELAY - 1);
            state_q   <= T_WAIT;
          end else if (tima_inc) tima_q <= tima_q + 8'd1;
        T_WAIT:
          if (we_tima) begin
            tima_q  <= wr_data;
            state_q <= T_RUN;
          end else begin
            if (tima_inc) tima_q <= tima_q + 8'd1;
            ovf_cnt_q <= ovf_cnt_q - 1'b1;
            if (ovf_cnt_q <= CW'(1)) state_q <= T_RELOAD;
          end
        T_RELOAD: begin
          // a TMA write in this cycle reaches TIMA directly; TIMA writes are dropped
          tima_q  <= we_tma ? wr_data : tma_q;
          state_q <= T_RUN;
        end
        default: state_q <= T_RUN;
      endcase
    end
endmodule
